me_stage: RTL and testbench
===========================

# me_stage

Parametrised memory stage for the b-risc pipeline, placed between execute and write-back. Non-memory instructions pass through a one-cycle pipeline register. Loads and stores are issued to data memory over a req/ack handshake, and the stage stalls upstream until the access completes. Load data is lane-extracted and sign- or zero-extended before write-back.

## Interface
- `ADDR_W`, 32: address width.
- `WORD_W`, 32: data word width; multiple of 8, at least 16.
- `INSTR_W`, 32: instruction width.
- `REG_IDX_W`, 5: register index width.
- `DEST_SRC_W`, 2: write-back source select width.
- `clk` in 1: clock.
- `clr` in 1: synchronous, active-high reset.
- `i_valid` in 1: execute presents an instruction.
- `i_pc` in `ADDR_W`: instruction PC.
- `i_instr` in `INSTR_W`: instruction word.
- `i_dest_src` in `DEST_SRC_W`: write-back source select.
- `i_dest_reg` in `REG_IDX_W`: destination register.
- `i_alu_eval` in `WORD_W`: ALU result, or effective address for memory ops.
- `i_store_data` in `WORD_W`: store data, right-aligned.
- `i_mem_op` in 2: 0 none, 1 load, 2 store, 3 reserved (treated as none).
- `i_mem_size` in 2: access is 2^size bytes; size must satisfy 2^size ≤ `WORD_W`/8.
- `i_mem_signed` in 1: sign-extend load data.
- `o_stall` out 1: upstream holds its outputs.
- `o_dmem_req` out 1: memory request.
- `o_dmem_we` out 1: write enable.
- `o_dmem_addr` out `ADDR_W`: word-aligned address.
- `o_dmem_wdata` out `WORD_W`: lane-replicated store data.
- `o_dmem_be` out `WORD_W`/8: byte enables.
- `i_dmem_ack` in 1: access complete.
- `i_dmem_rdata` in `WORD_W`: read data; valid when `i_dmem_ack` is high.
- `o_valid` out 1: write-back payload valid.
- `o_pc`, `o_instr`, `o_dest_src`, `o_dest_reg`, `o_alu_eval` out: registered copies of the inputs.
- `o_load_data` out `WORD_W`: extended load result; 0 for non-loads.
- `o_misalign` out 1: misaligned access flag.

## Operation
- FSM states: IDLE, WAIT.
- IDLE, `i_valid`=0: next edge loads `o_valid`=0. Payload outputs hold.
- IDLE, `i_valid`=1, mem op none: next edge registers the payload, `o_valid`=1, `o_load_data`=0.
- IDLE, `i_valid`=1, load/store: next edge captures the payload and request fields and moves to WAIT. The same edge sets `o_dmem_req`=1 and `o_valid`=0.
- WAIT: `o_stall`=1. `i_*` inputs are ignored. Request outputs hold stable.
- WAIT, ack: on the edge where `i_dmem_ack`=1, drop `o_dmem_req`, register the payload and `o_load_data`, set `o_valid`=1, return to IDLE.
- `i_dmem_ack` is sampled only in WAIT.
- `o_stall` = (state == WAIT), decoded combinationally from state only.
- Lane: lane = `i_alu_eval`[log2(`WORD_W`/8)-1:0].
- `o_dmem_addr` = address with the lane bits zeroed.
- `o_dmem_be` = (2^(2^size) - 1) << lane.
- `o_dmem_wdata` = store data replicated into every lane.
- Load: `o_load_data` = (`i_dmem_rdata` >> 8·lane), masked to 8·2^size bits, then sign- or zero-extended per `i_mem_signed`.
- Size 2^size > `WORD_W`/8 is clamped to a full word.

## Timing
- Reset: `clr` forces state IDLE and sets every output to 0, including `o_dmem_req`, `o_stall`, `o_valid` and `o_misalign`.
- `clr` in WAIT abandons the access. A later ack is ignored.
- Non-memory latency: 1 cycle.
- Memory latency: 1 + N cycles, where N ≥ 1 counts WAIT cycles up to and including the ack. Minimum is 2 when ack arrives in the first WAIT cycle.
- Back-to-back memory ops: one IDLE cycle separates them; throughput is one access per 2 cycles minimum.
- `o_valid` stays low for every WAIT cycle (bubble to write-back).

## Configuration
- Macro: `ME_MISALIGN_CHECK_EN`.
- Defined: an access whose lane is not a multiple of 2^size issues no memory request. It completes in 1 cycle with `o_valid`=1, `o_misalign`=1, `o_dest_reg` forced to 0 and `o_load_data`=0.
- Undefined: `o_misalign` is tied to 0. The lane is aligned down to the access size and the access proceeds normally.

## Structure
- Shared header/package `me_pkg`: mem-op encodings, size encodings, FSM state encodings, and the `WORD_W`/8 lane-count constant.
- Sub-module `me_lane_align`: purely combinational. It generates the byte enables, replicates store data, and extracts and extends load data. It is instantiated once in `me_stage`.

## Test plan
- ALU pass-through: `i_valid`=1, op none, `i_alu_eval`=0x1234 → next cycle `o_valid`=1, `o_alu_eval`=0x1234, `o_load_data`=0, `o_stall`=0.
- Signed byte load: addr 0x103, rdata 0x80FF_FF00, ack after 3 WAIT cycles → `o_dmem_addr`=0x100, `o_dmem_be`=4'b1000, `o_stall` high for 3 cycles, then `o_load_data`=0xFFFF_FF80.
- Unsigned half load: addr 0x102, rdata 0xBEEF_0000, immediate ack → 2-cycle latency, `o_load_data`=0x0000_BEEF.
- Byte store: addr 0x101, data 0xAB → `o_dmem_we`=1, `o_dmem_be`=4'b0010, `o_dmem_wdata`=0xABAB_ABAB.
- Reset mid-access: `clr` in WAIT, then ack → all outputs 0, no `o_valid` pulse.
- Misaligned word load at addr 0x102:
  - with `ME_MISALIGN_CHECK_EN`: no `o_dmem_req`, `o_misalign`=1, `o_dest_reg`=0;
  - without it: `o_dmem_addr`=0x100 and the access is performed.

Source files
------------

// File: rtl/me_pkg.sv
// Shared encodings and helpers for the b-risc memory stage.
package me_pkg;

  typedef enum logic [1:0] {
    MEM_NONE  = 2'd0,
    MEM_LOAD  = 2'd1,
    MEM_STORE = 2'd2,
    MEM_RSVD  = 2'd3
  } mem_op_e;

  typedef enum logic [1:0] {
    SIZE_BYTE  = 2'd0,
    SIZE_HALF  = 2'd1,
    SIZE_WORD  = 2'd2,
    SIZE_DWORD = 2'd3
  } mem_size_e;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_WAIT = 1'b1
  } state_e;

  // Byte lanes in the default 32-bit data word.
  localparam int LANE_CNT = 32 / 8;

  // Access width in bytes; sizes wider than the data word clamp to a full word.
  function automatic int access_bytes(input logic [1:0] size, input int lanes);
    int bytes;
    bytes = 1 << size;
    return (bytes > lanes) ? lanes : bytes;
  endfunction

endpackage

// File: rtl/me_lane_align.sv
// Combinational byte-lane steering: byte enables, store replication, load extract/extend.
module me_lane_align
  import me_pkg::*;
#(
  parameter int WORD_W = 32,
  parameter int LANE_W = $clog2(WORD_W / 8)
) (
  input  logic [LANE_W-1:0]   lane,
  input  logic [1:0]          size,
  input  logic                sign_ext,
  input  logic [WORD_W-1:0]   store_data,
  input  logic [WORD_W-1:0]   rdata,
  output logic [WORD_W/8-1:0] be,
  output logic [WORD_W-1:0]   wdata,
  output logic [WORD_W-1:0]   load_data
);

  localparam int LANES = WORD_W / 8;
  localparam int IDX_W = $clog2(WORD_W);

  int               bytes;
  int               lane_al;
  logic [WORD_W-1:0] shifted;
  logic             fill;

  // Lane is aligned down to the access size so a stray low address bit never splits an access.
  always_comb begin
    bytes     = access_bytes(size, LANES);
    lane_al   = int'(lane) & ~(bytes - 1);
    shifted   = rdata >> (8 * lane_al);
    fill      = sign_ext & shifted[IDX_W'(8 * bytes - 1)];
    be        = '0;
    wdata     = '0;
    load_data = '0;
    for (int i = 0; i < LANES; i++) begin
      be[LANE_W'(i)] = (i >= lane_al) && (i < lane_al + bytes);
      wdata[IDX_W'(8 * i) +: 8] = store_data[IDX_W'(8 * (i & (bytes - 1))) +: 8];
      load_data[IDX_W'(8 * i) +: 8] = (i < bytes) ? shifted[IDX_W'(8 * i) +: 8] : {8{fill}};
    end
  end

endmodule

// File: rtl/me_stage.sv
// b-risc memory stage: pass-through register for ALU ops, req/ack data-memory access for loads/stores.
// Optional macro ME_MISALIGN_CHECK_EN traps misaligned accesses instead of aligning them down.
module me_stage
  import me_pkg::*;
#(
  parameter int ADDR_W     = 32,
  parameter int WORD_W     = 32,
  parameter int INSTR_W    = 32,
  parameter int REG_IDX_W  = 5,
  parameter int DEST_SRC_W = 2
) (
  input  logic                  clk,
  input  logic                  clr,
  input  logic                  i_valid,
  input  logic [ADDR_W-1:0]     i_pc,
  input  logic [INSTR_W-1:0]    i_instr,
  input  logic [DEST_SRC_W-1:0] i_dest_src,
  input  logic [REG_IDX_W-1:0]  i_dest_reg,
  input  logic [WORD_W-1:0]     i_alu_eval,
  input  logic [WORD_W-1:0]     i_store_data,
  input  logic [1:0]            i_mem_op,
  input  logic [1:0]            i_mem_size,
  input  logic                  i_mem_signed,
  output logic                  o_stall,
  output logic                  o_dmem_req,
  output logic                  o_dmem_we,
  output logic [ADDR_W-1:0]     o_dmem_addr,
  output logic [WORD_W-1:0]     o_dmem_wdata,
  output logic [WORD_W/8-1:0]   o_dmem_be,
  input  logic                  i_dmem_ack,
  input  logic [WORD_W-1:0]     i_dmem_rdata,
  output logic                  o_valid,
  output logic [ADDR_W-1:0]     o_pc,
  output logic [INSTR_W-1:0]    o_instr,
  output logic [DEST_SRC_W-1:0] o_dest_src,
  output logic [REG_IDX_W-1:0]  o_dest_reg,
  output logic [WORD_W-1:0]     o_alu_eval,
  output logic [WORD_W-1:0]     o_load_data,
  output logic                  o_misalign
);

  localparam int LANES  = WORD_W / 8;
  localparam int LANE_W = $clog2(LANES);

  state_e state, state_next;

  logic [ADDR_W-1:0]     pend_pc;
  logic [INSTR_W-1:0]    pend_instr;
  logic [DEST_SRC_W-1:0] pend_dest_src;
  logic [REG_IDX_W-1:0]  pend_dest_reg;
  logic [WORD_W-1:0]     pend_alu;
  logic [LANE_W-1:0]     pend_lane;
  logic [1:0]            pend_size;
  logic                  pend_signed;
  logic                  pend_load;

  logic                  is_mem, mis_trap, start_mem;
  logic [LANE_W-1:0]     lane_in, lane_sel;
  logic [1:0]            size_sel;
  logic                  signed_sel;
  logic [LANES-1:0]      be;
  logic [WORD_W-1:0]     wdata, load_data;

  assign lane_in = i_alu_eval[LANE_W-1:0];
  assign is_mem  = (i_mem_op == MEM_LOAD) || (i_mem_op == MEM_STORE);

`ifdef ME_MISALIGN_CHECK_EN
  assign mis_trap = is_mem && ((int'(lane_in) & (access_bytes(i_mem_size, LANES) - 1)) != 0);
`else
  assign mis_trap = 1'b0;
`endif

  assign start_mem = i_valid && is_mem && !mis_trap;
  assign o_stall   = (state == ST_WAIT);

  // While waiting, the lane logic must see the captured request, not the (ignored) inputs.
  assign lane_sel   = o_stall ? pend_lane   : lane_in;
  assign size_sel   = o_stall ? pend_size   : i_mem_size;
  assign signed_sel = o_stall ? pend_signed : i_mem_signed;

  me_lane_align #(.WORD_W(WORD_W), .LANE_W(LANE_W)) u_align (
    .lane       (lane_sel),
    .size       (size_sel),
    .sign_ext   (signed_sel),
    .store_data (i_store_data),
    .rdata      (i_dmem_rdata),
    .be         (be),
    .wdata      (wdata),
    .load_data  (load_data)
  );

  always_ff @(posedge clk) begin
    if (clr) state <= ST_IDLE;
    else     state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      ST_IDLE: if (start_mem) state_next = ST_WAIT;
      ST_WAIT: if (i_dmem_ack) state_next = ST_IDLE;
      default: state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (clr) begin
      o_dmem_req    <= 1'b0;
      o_dmem_we     <= 1'b0;
      o_dmem_addr   <= '0;
      o_dmem_wdata  <= '0;
      o_dmem_be     <= '0;
      o_valid       <= 1'b0;
      o_pc          <= '0;
      o_instr       <= '0;
      o_dest_src    <= '0;
      o_dest_reg    <= '0;
      o_alu_eval    <= '0;
      o_load_data   <= '0;
      o_misalign    <= 1'b0;
      pend_pc       <= '0;
      pend_instr    <= '0;
      pend_dest_src <= '0;
      pend_dest_reg <= '0;
      pend_alu      <= '0;
      pend_lane     <= '0;
      pend_size     <= '0;
      pend_signed   <= 1'b0;
      pend_load     <= 1'b0;
    end else if (state == ST_IDLE) begin
      o_valid <= 1'b0;
      if (start_mem) begin
        pend_pc       <= i_pc;
        pend_instr    <= i_instr;
        pend_dest_src <= i_dest_src;
        pend_dest_reg <= i_dest_reg;
        pend_alu      <= i_alu_eval;
        pend_lane     <= lane_in;
        pend_size     <= i_mem_size;
        pend_signed   <= i_mem_signed;
        pend_load     <= (i_mem_op == MEM_LOAD);
        o_dmem_req    <= 1'b1;
        o_dmem_we     <= (i_mem_op == MEM_STORE);
        o_dmem_addr   <= ADDR_W'(i_alu_eval) & ~ADDR_W'(LANES - 1);
        o_dmem_wdata  <= wdata;
        o_dmem_be     <= be;
        o_misalign    <= 1'b0;
      end else if (i_valid) begin
        // Plain ALU ops and trapped misaligned accesses both retire in one cycle.
        o_valid     <= 1'b1;
        o_pc        <= i_pc;
        o_instr     <= i_instr;
        o_dest_src  <= i_dest_src;
        o_dest_reg  <= mis_trap ? '0 : i_dest_reg;
        o_alu_eval  <= i_alu_eval;
        o_load_data <= '0;
        o_misalign  <= mis_trap;
      end
    end else if (i_dmem_ack) begin
      o_dmem_req  <= 1'b0;
      o_valid     <= 1'b1;
      o_pc        <= pend_pc;
      o_instr     <= pend_instr;
      o_dest_src  <= pend_dest_src;
      o_dest_reg  <= pend_dest_reg;
      o_alu_eval  <= pend_alu;
      o_load_data <= pend_load ? load_data : '0;
      o_misalign  <= 1'b0;
    end
  end

endmodule

// File: tb/tb_me_stage.sv
// Self-checking bench for me_stage: vector table plus scoreboard, with reset and misalign sequences.
module tb_me_stage;

  logic        clk = 1'b0;
  logic        clr;
  logic        i_valid;
  logic [31:0] i_pc, i_instr, i_alu_eval, i_store_data, i_dmem_rdata;
  logic [1:0]  i_dest_src, i_mem_op, i_mem_size;
  logic [4:0]  i_dest_reg;
  logic        i_mem_signed, i_dmem_ack;
  logic        o_stall, o_dmem_req, o_dmem_we, o_valid, o_misalign;
  logic [31:0] o_dmem_addr, o_dmem_wdata, o_pc, o_instr, o_alu_eval, o_load_data;
  logic [3:0]  o_dmem_be;
  logic [1:0]  o_dest_src;
  logic [4:0]  o_dest_reg;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [1:0]  op;
    logic [1:0]  size;
    logic        sgn;
    logic [31:0] addr;
    logic [31:0] sdata;
    logic [31:0] rdata;
    int          n;
    logic [31:0] exp_addr;
    logic [3:0]  exp_be;
    logic [31:0] exp_wdata;
    logic [31:0] exp_load;
  } vec_t;

  typedef struct {
    logic [31:0] pc;
    logic [31:0] instr;
    logic [1:0]  dest_src;
    logic [4:0]  dest_reg;
    logic [31:0] alu;
    logic [31:0] load;
    logic        mis;
  } exp_t;

  vec_t vecs[$];
  exp_t sb[$];

  me_stage dut (
    .clk(clk), .clr(clr), .i_valid(i_valid), .i_pc(i_pc), .i_instr(i_instr),
    .i_dest_src(i_dest_src), .i_dest_reg(i_dest_reg), .i_alu_eval(i_alu_eval),
    .i_store_data(i_store_data), .i_mem_op(i_mem_op), .i_mem_size(i_mem_size),
    .i_mem_signed(i_mem_signed), .o_stall(o_stall), .o_dmem_req(o_dmem_req),
    .o_dmem_we(o_dmem_we), .o_dmem_addr(o_dmem_addr), .o_dmem_wdata(o_dmem_wdata),
    .o_dmem_be(o_dmem_be), .i_dmem_ack(i_dmem_ack), .i_dmem_rdata(i_dmem_rdata),
    .o_valid(o_valid), .o_pc(o_pc), .o_instr(o_instr), .o_dest_src(o_dest_src),
    .o_dest_reg(o_dest_reg), .o_alu_eval(o_alu_eval), .o_load_data(o_load_data),
    .o_misalign(o_misalign)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic vec_t mk(input logic [1:0] op, input logic [1:0] size, input logic sgn,
                              input logic [31:0] addr, input logic [31:0] sdata,
                              input logic [31:0] rdata, input int n, input logic [31:0] ea,
                              input logic [3:0] ebe, input logic [31:0] ew, input logic [31:0] el);
    vec_t v;
    v.op = op; v.size = size; v.sgn = sgn; v.addr = addr; v.sdata = sdata; v.rdata = rdata;
    v.n = n; v.exp_addr = ea; v.exp_be = ebe; v.exp_wdata = ew; v.exp_load = el;
    return v;
  endfunction

  // Pops the oldest expected result and compares it with the retiring payload.
  task automatic checkOutput();
    exp_t e;
    check("valid", o_valid, 1);
    check("stall_after", o_stall, 0);
    check("req_dropped", o_dmem_req, 0);
    if (sb.size() == 0) begin
      checks++;
      errors++;
      $display("[TB] FAIL scoreboard: got o_valid with no expected entry");
    end else begin
      e = sb.pop_front();
      check("pc", o_pc, e.pc);
      check("instr", o_instr, e.instr);
      check("dest_src", o_dest_src, e.dest_src);
      check("dest_reg", o_dest_reg, e.dest_reg);
      check("alu_eval", o_alu_eval, e.alu);
      check("load_data", o_load_data, e.load);
      check("misalign", o_misalign, e.mis);
    end
  endtask

  task automatic applyStimulus(input vec_t v, input int idx);
    exp_t e;
    logic is_mem;
    is_mem       = (v.op == 2'd1) || (v.op == 2'd2);
    i_valid      = 1'b1;
    i_pc         = 32'h1000 + 32'(idx * 4);
    i_instr      = 32'hA000_0000 | 32'(idx);
    i_dest_src   = 2'(idx);
    i_dest_reg   = 5'(idx + 1);
    i_alu_eval   = v.addr;
    i_store_data = v.sdata;
    i_mem_op     = v.op;
    i_mem_size   = v.size;
    i_mem_signed = v.sgn;
    e.pc = i_pc; e.instr = i_instr; e.dest_src = i_dest_src; e.dest_reg = i_dest_reg;
    e.alu = v.addr; e.load = v.exp_load; e.mis = 1'b0;
    sb.push_back(e);
    tick();
    if (is_mem) begin
      // Scramble inputs during WAIT: the stage must work from captured fields only.
      i_valid      = 1'b0;
      i_alu_eval   = 32'hFFFF_FFFF;
      i_store_data = 32'h5555_5555;
      i_mem_op     = 2'd2;
      i_mem_size   = 2'd0;
      i_mem_signed = ~v.sgn;
      check("req", o_dmem_req, 1);
      check("we", o_dmem_we, (v.op == 2'd2));
      check("addr", o_dmem_addr, v.exp_addr);
      check("be", o_dmem_be, v.exp_be);
      check("wdata", o_dmem_wdata, v.exp_wdata);
      for (int k = 1; k <= v.n; k++) begin
        if (k == v.n) begin
          i_dmem_ack   = 1'b1;
          i_dmem_rdata = v.rdata;
        end
        check("stall_wait", o_stall, 1);
        check("valid_wait", o_valid, 0);
        check("req_hold", o_dmem_req, 1);
        tick();
      end
      i_dmem_ack   = 1'b0;
      i_dmem_rdata = 32'hDEAD_0000;
    end else begin
      i_valid = 1'b0;
    end
    checkOutput();
  endtask

  initial begin
    clr = 1'b1; i_valid = 1'b1; i_pc = 32'h4; i_instr = 32'h13; i_dest_src = 2'd1;
    i_dest_reg = 5'd3; i_alu_eval = 32'h77; i_store_data = 32'h0; i_mem_op = 2'd1;
    i_mem_size = 2'd2; i_mem_signed = 1'b0; i_dmem_ack = 1'b0; i_dmem_rdata = 32'h0;
    tick();
    tick();
    check("rst_valid", o_valid, 0);
    check("rst_stall", o_stall, 0);
    check("rst_req", o_dmem_req, 0);
    check("rst_misalign", o_misalign, 0);
    check("rst_alu", o_alu_eval, 0);
    check("rst_addr", o_dmem_addr, 0);
    check("rst_be", o_dmem_be, 0);
    check("rst_dest", o_dest_reg, 0);
    clr = 1'b0;
    i_valid = 1'b0;
    tick();

    //                op    sz    sgn  addr          sdata         rdata         n  exp_addr      be       wdata         load
    vecs.push_back(mk(2'd0, 2'd0, 0, 32'h0000_1234, 32'h0,        32'h0,        0, 32'h0,        4'b0000, 32'h0,        32'h0));
    vecs.push_back(mk(2'd3, 2'd0, 0, 32'h0000_0055, 32'h0,        32'h0,        0, 32'h0,        4'b0000, 32'h0,        32'h0));
    vecs.push_back(mk(2'd1, 2'd0, 1, 32'h0000_0103, 32'h0,        32'h80FF_FF00, 3, 32'h100,     4'b1000, 32'h0,        32'hFFFF_FF80));
    vecs.push_back(mk(2'd1, 2'd1, 0, 32'h0000_0102, 32'h0,        32'hBEEF_0000, 1, 32'h100,     4'b1100, 32'h0,        32'h0000_BEEF));
    vecs.push_back(mk(2'd2, 2'd0, 0, 32'h0000_0101, 32'h1234_56AB, 32'h0,       2, 32'h100,     4'b0010, 32'hABAB_ABAB, 32'h0));
    vecs.push_back(mk(2'd2, 2'd1, 0, 32'h0000_0206, 32'h0000_CAFE, 32'h0,       1, 32'h204,     4'b1100, 32'hCAFE_CAFE, 32'h0));
    vecs.push_back(mk(2'd2, 2'd2, 0, 32'h0000_0300, 32'hDEAD_BEEF, 32'h0,       1, 32'h300,     4'b1111, 32'hDEAD_BEEF, 32'h0));
    vecs.push_back(mk(2'd1, 2'd2, 1, 32'h0000_0404, 32'h0,        32'h89AB_CDEF, 2, 32'h404,     4'b1111, 32'h0,        32'h89AB_CDEF));
    vecs.push_back(mk(2'd1, 2'd1, 1, 32'h0000_0010, 32'h0,        32'h1234_8001, 1, 32'h010,     4'b0011, 32'h0,        32'hFFFF_8001));
    vecs.push_back(mk(2'd1, 2'd0, 0, 32'h0000_0021, 32'h0,        32'h0000_F000, 1, 32'h020,     4'b0010, 32'h0,        32'h0000_00F0));
    vecs.push_back(mk(2'd1, 2'd3, 0, 32'h0000_0500, 32'h0,        32'h1122_3344, 1, 32'h500,     4'b1111, 32'h0,        32'h1122_3344));
`ifndef ME_MISALIGN_CHECK_EN
    vecs.push_back(mk(2'd1, 2'd2, 0, 32'h0000_0102, 32'h0,        32'hA1B2_C3D4, 1, 32'h100,     4'b1111, 32'h0,        32'hA1B2_C3D4));
    vecs.push_back(mk(2'd1, 2'd1, 1, 32'h0000_0601, 32'h0,        32'h7F00_8080, 2, 32'h600,     4'b0011, 32'h0,        32'hFFFF_8080));
`endif

    foreach (vecs[i]) applyStimulus(vecs[i], i);

    // With no new instruction the bubble drops o_valid but the payload holds.
    tick();
    check("idle_valid", o_valid, 0);
    check("idle_alu_hold", o_alu_eval, vecs[vecs.size() - 1].addr);
    check("idle_load_hold", o_load_data, vecs[vecs.size() - 1].exp_load);

    // Reset while waiting abandons the access; a late ack must not retire anything.
    i_valid = 1'b1; i_alu_eval = 32'h0000_0042; i_mem_op = 2'd1; i_mem_size = 2'd0;
    i_mem_signed = 1'b0; i_dest_reg = 5'd9;
    tick();
    i_valid = 1'b0;
    check("abort_stall", o_stall, 1);
    tick();
    clr = 1'b1;
    tick();
    clr = 1'b0;
    i_dmem_ack = 1'b1;
    i_dmem_rdata = 32'hFFFF_FFFF;
    check("abort_valid", o_valid, 0);
    check("abort_stall_clr", o_stall, 0);
    check("abort_req", o_dmem_req, 0);
    check("abort_addr", o_dmem_addr, 0);
    check("abort_be", o_dmem_be, 0);
    check("abort_alu", o_alu_eval, 0);
    for (int k = 0; k < 2; k++) begin
      tick();
      check("late_ack_valid", o_valid, 0);
      check("late_ack_req", o_dmem_req, 0);
      check("late_ack_load", o_load_data, 0);
    end
    i_dmem_ack = 1'b0;

`ifdef ME_MISALIGN_CHECK_EN
    begin
      exp_t e;
      i_valid = 1'b1; i_pc = 32'h2000; i_instr = 32'h0000_0ABC; i_dest_src = 2'd2;
      i_dest_reg = 5'd7; i_alu_eval = 32'h0000_0102; i_mem_op = 2'd1; i_mem_size = 2'd2;
      e.pc = 32'h2000; e.instr = 32'h0000_0ABC; e.dest_src = 2'd2; e.dest_reg = 5'd0;
      e.alu = 32'h0000_0102; e.load = 32'h0; e.mis = 1'b1;
      sb.push_back(e);
      tick();
      i_valid = 1'b0;
      checkOutput();
    end
`endif

    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("[TB] FAIL scoreboard_drain: got %0d pending expected 0", sb.size());
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
